// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Merges the fetch and data requesters onto one memory port, one transaction
// at a time; data has priority, bounded by a fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    localparam int unsigned MASK_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [MASK_W-1:0] d_wmask,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              err
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic d_valid;
    logic starve;

    assign d_valid = d_read ^ d_write;
    assign starve  = (cnt_q == CNT_MAX) && i_read;

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            addr_q    <= '0;
            wmask_q   <= '0;
            wdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_resp_q  <= 1'b0;
            d_resp_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_resp_q  <= i_resp_d;
            d_resp_q  <= d_resp_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Grant, transfer and response sequencing.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        read_d    = read_q;
        write_d   = write_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_resp_d  = 1'b0;
        d_resp_d  = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if ((d_read && d_write) || mem_resp) begin
                    err_d = 1'b1;
                end
                if (d_valid && !starve) begin
                    state_d = BUSY;
                    owner_d = OWN_D;
                    addr_d  = d_addr;
                    read_d  = d_read;
                    write_d = d_write;
                    wmask_d = d_write ? d_wmask : '0;
                    wdata_d = d_write ? d_wdata : '0;
                    if (!i_read) begin
                        cnt_d = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (i_read) begin
                    state_d = BUSY;
                    owner_d = OWN_I;
                    addr_d  = i_addr;
                    read_d  = 1'b1;
                    write_d = 1'b0;
                    wmask_d = '0;
                    wdata_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d = RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (owner_q == OWN_I) begin
                        i_resp_d = 1'b1;
                        if (read_q) begin
                            i_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_resp_d = 1'b1;
                        if (read_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                if (mem_resp) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_rdata   = i_rdata_q;
    assign i_resp    = i_resp_q;
    assign d_rdata   = d_rdata_q;
    assign d_resp    = d_resp_q;
    assign mem_addr  = addr_q;
    assign mem_read  = read_q;
    assign mem_write = write_q;
    assign mem_wmask = wmask_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule
